// File: rtl/sd_wb_slave_regs_if.sv
// Wishbone B4 bus bundle between the system master and the SD controller slave.
// Signal names follow the controller's original (master-side) naming.
interface sd_wb_slave_regs_if #(
   parameter int DATA_W = 32
) ();
   logic              CYC_O;
   logic              STB_O;
   logic              WE_O;
   logic              SEL_O;
   logic [6:4]        ADR_O;
   logic [DATA_W-1:0] DAT_O;
   logic [2:0]        CTI_O;
   logic              ACK_I;
   logic              ERR_I;
   logic              RTY_I;
   logic [DATA_W-1:0] DAT_I;

   modport master (
      output CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O, CTI_O,
      input  ACK_I, ERR_I, RTY_I, DAT_I
   );

   // SEL_O is whole-word only, so the slave never looks at it.
   modport slave (
      input  CYC_O, STB_O, WE_O, ADR_O, DAT_O, CTI_O,
      output ACK_I, ERR_I, RTY_I, DAT_I
   );
endinterface

// File: rtl/sd_wb_slave_regs.sv
// Wishbone slave for the SD controller: register bank, op handshake and
// read/write FIFO ports, with registered termination and constant-address bursts.
module sd_wb_slave_regs #(
   parameter int DATA_W = 32
) (
   input  logic              CLK_I,
   input  logic              RST_I,
   sd_wb_slave_regs_if.slave wb,
   output logic              oOpValid,
   output logic [DATA_W-1:0] oOpCode,
   output logic [DATA_W-1:0] oStartAddr,
   output logic [DATA_W-1:0] oEndAddr,
   input  logic              iOpAck,
   input  logic              iCtrlBusy,
   input  logic [DATA_W-1:0] iRdData,
   input  logic              iRdEmpty,
   output logic              oRdPop,
   output logic [DATA_W-1:0] oWrData,
   output logic              oWrPush,
   input  logic              iWrFull
);
   typedef enum logic [1:0] {S_IDLE, S_BURST, S_TERM} state_t;

   localparam logic [2:0] CTI_CONST = 3'b001;

   state_t            state_q, state_d;
   logic              ack_q, ack_d, err_q, err_d, rty_q, rty_d;
   logic              op_valid_q, op_valid_d, wr_push_q, wr_push_d;
   logic [DATA_W-1:0] dat_q, dat_d, op_code_q, op_code_d;
   logic [DATA_W-1:0] start_q, start_d, end_q, end_d, wr_data_q, wr_data_d;

   logic              req, we, dec_err, dec_rty, dec_ack;
   logic [2:0]        adr;
   logic [DATA_W-1:0] status;

   // Beat decode; TERM refuses requests so a stale STB after a classic ACK is ignored.
   always_comb begin
      adr     = wb.ADR_O;
      we      = wb.WE_O;
      req     = RST_I & wb.CYC_O & wb.STB_O & (state_q != S_TERM);
      dec_err = (adr == 3'd6) | (adr == 3'd7)
              | (we & ((adr == 3'd0) | (adr == 3'd4)))
              | (~we & (adr == 3'd5));
      dec_rty = ~dec_err & ((~we & (adr == 3'd4) & iRdEmpty)
                          | (we & (adr == 3'd5) & iWrFull)
                          | (we & (adr == 3'd1) & op_valid_q));
      dec_ack = ~dec_err & ~dec_rty;
      status  = {{(DATA_W-4){1'b0}}, iWrFull, iRdEmpty, iCtrlBusy, op_valid_q};
   end

   assign oRdPop = req & dec_ack & ~we & (adr == 3'd4);

   always_comb begin
      state_d    = state_q;
      ack_d      = req & dec_ack;
      err_d      = req & dec_err;
      rty_d      = req & dec_rty;
      dat_d      = dat_q;
      op_code_d  = op_code_q;
      start_d    = start_q;
      end_d      = end_q;
      op_valid_d = op_valid_q & ~iOpAck;
      wr_push_d  = req & dec_ack & we & (adr == 3'd5);
      wr_data_d  = wr_push_d ? wb.DAT_O : wr_data_q;

      if (req & dec_ack) begin
         if (we) begin
            case (adr)
               3'd1: begin
                  op_code_d  = wb.DAT_O;
                  op_valid_d = 1'b1;
               end
               3'd2:    start_d = wb.DAT_O;
               3'd3:    end_d   = wb.DAT_O;
               default: ;
            endcase
         end else begin
            case (adr)
               3'd0:    dat_d = status;
               3'd1:    dat_d = op_code_q;
               3'd2:    dat_d = start_q;
               3'd3:    dat_d = end_q;
               3'd4:    dat_d = iRdData;
               default: ;
            endcase
         end
      end

      // A burst continues only on CTI=001 beats that are ACKed.
      case (state_q)
         S_IDLE: begin
            if (req)
               state_d = (wb.CTI_O == CTI_CONST && dec_ack) ? S_BURST : S_TERM;
         end
         S_BURST: begin
            if (!wb.CYC_O)
               state_d = S_IDLE;
            else if (req && (wb.CTI_O != CTI_CONST || !dec_ack))
               state_d = S_TERM;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (!RST_I) begin
         state_q    <= S_IDLE;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rty_q      <= 1'b0;
         op_valid_q <= 1'b0;
         wr_push_q  <= 1'b0;
         dat_q      <= '0;
         op_code_q  <= '0;
         start_q    <= '0;
         end_q      <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rty_q      <= rty_d;
         op_valid_q <= op_valid_d;
         wr_push_q  <= wr_push_d;
         dat_q      <= dat_d;
         op_code_q  <= op_code_d;
         start_q    <= start_d;
         end_q      <= end_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign wb.ACK_I   = ack_q;
   assign wb.ERR_I   = err_q;
   assign wb.RTY_I   = rty_q;
   assign wb.DAT_I   = dat_q;
   assign oOpValid   = op_valid_q;
   assign oOpCode    = op_code_q;
   assign oStartAddr = start_q;
   assign oEndAddr   = end_q;
   assign oWrPush    = wr_push_q;
   assign oWrData    = wr_data_q;
endmodule

// File: tb/tb_sd_wb_slave_regs.sv
// Directed bench for sd_wb_slave_regs: classic and burst cycles, op handshake,
// FIFO ports, error/retry terminations and reset in the middle of a burst.
module tb_sd_wb_slave_regs;
   localparam logic [31:0] T_NONE = 32'd0;
   localparam logic [31:0] T_ACK  = 32'd1;
   localparam logic [31:0] T_RTY  = 32'd2;
   localparam logic [31:0] T_ERR  = 32'd4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iOpAck, iCtrlBusy, iWrFull;
   logic        oOpValid, oRdPop, oWrPush, iRdEmpty;
   logic [31:0] oOpCode, oStartAddr, oEndAddr, oWrData, iRdData;

   logic [31:0] rd_mem [0:3];
   int          rd_fill;
   int          pop_cnt  = 0;
   int          push_cnt = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   sd_wb_slave_regs_if #(.DATA_W(32)) wb ();

   sd_wb_slave_regs #(.DATA_W(32)) dut (
      .CLK_I      (clk),
      .RST_I      (rst_n),
      .wb         (wb),
      .oOpValid   (oOpValid),
      .oOpCode    (oOpCode),
      .oStartAddr (oStartAddr),
      .oEndAddr   (oEndAddr),
      .iOpAck     (iOpAck),
      .iCtrlBusy  (iCtrlBusy),
      .iRdData    (iRdData),
      .iRdEmpty   (iRdEmpty),
      .oRdPop     (oRdPop),
      .oWrData    (oWrData),
      .oWrPush    (oWrPush),
      .iWrFull    (iWrFull)
   );

   always #5 clk = ~clk;

   // Show-ahead read FIFO preloaded with rd_fill words.
   assign iRdData  = rd_mem[pop_cnt[1:0]];
   assign iRdEmpty = (pop_cnt >= rd_fill);

   always @(posedge clk) begin
      if (oRdPop)  pop_cnt  <= pop_cnt + 1;
      if (oWrPush) push_cnt <= push_cnt + 1;
   end

   function automatic logic [31:0] term();
      return {29'd0, wb.ERR_I, wb.RTY_I, wb.ACK_I};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                       input logic [2:0] cti);
      wb.CYC_O = 1'b1;
      wb.STB_O = 1'b1;
      wb.WE_O  = we;
      wb.ADR_O = adr;
      wb.DAT_O = dat;
      wb.CTI_O = cti;
      @(posedge clk);
      #1;
      $display("txn we=%0b adr=%0d cti=%03b dat_o=0x%08h -> term=%0d dat_i=0x%08h",
               we, adr, cti, dat, term(), wb.DAT_I);
   endtask

   task automatic idle();
      wb.CYC_O = 1'b0;
      wb.STB_O = 1'b0;
      wb.CTI_O = 3'b000;
      @(posedge clk);
      #1;
   endtask

   task automatic classic(input string tag, input logic we, input logic [2:0] adr,
                          input logic [31:0] dat, input logic [31:0] exp_term,
                          input logic [31:0] exp_dat);
      beat(we, adr, dat, 3'b000);
      check({tag, "_term"}, term(), exp_term);
      if (!we && exp_term == T_ACK) check({tag, "_data"}, wb.DAT_I, exp_dat);
      idle();
      check({tag, "_drop"}, term(), T_NONE);
   endtask

   initial begin
      rd_mem[0] = 32'hA000_000A;
      rd_mem[1] = 32'hB000_000B;
      rd_mem[2] = 32'hC000_000C;
      rd_mem[3] = 32'hDEAD_DEAD;
      rd_fill   = 3;
      rst_n     = 1'b0;
      iOpAck    = 1'b0;
      iCtrlBusy = 1'b0;
      iWrFull   = 1'b0;
      wb.CYC_O  = 1'b0;
      wb.STB_O  = 1'b0;
      wb.WE_O   = 1'b0;
      wb.SEL_O  = 1'b1;
      wb.ADR_O  = 3'd0;
      wb.DAT_O  = 32'd0;
      wb.CTI_O  = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_term", term(), T_NONE);
      check("rst_dat", wb.DAT_I, 32'd0);
      check("rst_opvalid", {31'd0, oOpValid}, 32'd0);
      check("rst_opcode", oOpCode, 32'd0);
      check("rst_push", {31'd0, oWrPush}, 32'd0);
      check("rst_wrdata", oWrData, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Classic register access
      classic("wr_start", 1'b1, 3'd2, 32'h0000_1234, T_ACK, 32'd0);
      check("start_reg", oStartAddr, 32'h0000_1234);
      classic("rd_start", 1'b0, 3'd2, 32'd0, T_ACK, 32'h0000_1234);
      classic("wr_end", 1'b1, 3'd3, 32'h0000_BEEF, T_ACK, 32'd0);
      check("end_reg", oEndAddr, 32'h0000_BEEF);

      // Op handshake: pending for 4 cycles, second write retried
      beat(1'b1, 3'd1, 32'h5, 3'b000);
      check("op_term", term(), T_ACK);
      check("op_valid0", {31'd0, oOpValid}, 32'd1);
      check("op_code", oOpCode, 32'h5);
      idle();
      check("op_valid1", {31'd0, oOpValid}, 32'd1);
      beat(1'b1, 3'd1, 32'h9, 3'b000);
      check("op2_term", term(), T_RTY);
      check("op_valid2", {31'd0, oOpValid}, 32'd1);
      idle();
      check("op_valid3", {31'd0, oOpValid}, 32'd1);
      check("op_code_kept", oOpCode, 32'h5);
      iOpAck = 1'b1;
      @(posedge clk);
      #1;
      iOpAck = 1'b0;
      check("op_cleared", {31'd0, oOpValid}, 32'd0);

      // Constant-address read burst from the FIFO: A, B, C, then retry on empty
      beat(1'b0, 3'd4, 32'd0, 3'b001);
      check("brd1_term", term(), T_ACK);
      check("brd1_data", wb.DAT_I, 32'hA000_000A);
      beat(1'b0, 3'd4, 32'd0, 3'b001);
      check("brd2_term", term(), T_ACK);
      check("brd2_data", wb.DAT_I, 32'hB000_000B);
      beat(1'b0, 3'd4, 32'd0, 3'b001);
      check("brd3_term", term(), T_ACK);
      check("brd3_data", wb.DAT_I, 32'hC000_000C);
      beat(1'b0, 3'd4, 32'd0, 3'b111);
      check("brd4_term", term(), T_RTY);
      check("brd4_data", wb.DAT_I, 32'hC000_000C);
      check("pop_count", pop_cnt, 32'd3);
      beat(1'b0, 3'd2, 32'd0, 3'b000);
      check("term_state_ignores", term(), T_NONE);
      beat(1'b0, 3'd2, 32'd0, 3'b000);
      check("after_term_term", term(), T_ACK);
      check("after_term_data", wb.DAT_I, 32'h0000_1234);
      idle();
      check("after_term_drop", term(), T_NONE);

      // Write burst to the FIFO; full on beat 3
      beat(1'b1, 3'd5, 32'h1111_0001, 3'b001);
      check("bwr1_term", term(), T_ACK);
      check("bwr1_push", {31'd0, oWrPush}, 32'd1);
      check("bwr1_data", oWrData, 32'h1111_0001);
      beat(1'b1, 3'd5, 32'h2222_0002, 3'b001);
      check("bwr2_term", term(), T_ACK);
      check("bwr2_data", oWrData, 32'h2222_0002);
      iWrFull = 1'b1;
      beat(1'b1, 3'd5, 32'h3333_0003, 3'b001);
      check("bwr3_term", term(), T_RTY);
      check("bwr3_push", {31'd0, oWrPush}, 32'd0);
      idle();
      check("push_count", push_cnt, 32'd2);
      check("wrdata_kept", oWrData, 32'h2222_0002);

      // Error terminations leave state alone
      classic("rd_unmapped", 1'b0, 3'd6, 32'd0, T_ERR, 32'd0);
      classic("wr_unmapped", 1'b1, 3'd7, 32'h7777_7777, T_ERR, 32'd0);
      classic("wr_status", 1'b1, 3'd0, 32'hFFFF_FFFF, T_ERR, 32'd0);
      classic("rd_wrdata", 1'b0, 3'd5, 32'd0, T_ERR, 32'd0);
      classic("wr_rddata", 1'b1, 3'd4, 32'h4444_4444, T_ERR, 32'd0);
      check("err_opcode", oOpCode, 32'h5);
      check("err_push", push_cnt, 32'd2);
      check("err_pop", pop_cnt, 32'd3);

      // Status: {iWrFull, iRdEmpty, iCtrlBusy, oOpValid}
      iCtrlBusy = 1'b1;
      classic("status_e", 1'b0, 3'd0, 32'd0, T_ACK, 32'h0000_000E);
      iCtrlBusy = 1'b0;
      iWrFull   = 1'b0;
      classic("status_4", 1'b0, 3'd0, 32'd0, T_ACK, 32'h0000_0004);

      // Reset in the middle of a burst with an op pending
      classic("op7", 1'b1, 3'd1, 32'h7, T_ACK, 32'd0);
      check("op7_valid", {31'd0, oOpValid}, 32'd1);
      classic("status_pend", 1'b0, 3'd0, 32'd0, T_ACK, 32'h0000_0005);
      beat(1'b0, 3'd3, 32'd0, 3'b001);
      check("mid_term", term(), T_ACK);
      check("mid_data", wb.DAT_I, 32'h0000_BEEF);
      rst_n = 1'b0;
      beat(1'b0, 3'd3, 32'd0, 3'b001);
      check("mrst_term", term(), T_NONE);
      check("mrst_dat", wb.DAT_I, 32'd0);
      check("mrst_opvalid", {31'd0, oOpValid}, 32'd0);
      check("mrst_opcode", oOpCode, 32'd0);
      check("mrst_start", oStartAddr, 32'd0);
      check("mrst_end", oEndAddr, 32'd0);
      idle();
      rst_n = 1'b1;
      idle();
      classic("post_rst_rd", 1'b0, 3'd2, 32'd0, T_ACK, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
